instruction_fetch: RTL and testbench

- Fetch stage directly upstream of the control decoder.
- Owns the PC and issues in-order word fetches to instruction memory over a valid/ready request channel with a valid-only response channel.
- Buffers returned words in a small queue and presents {instruction, pc} to decode with a valid/ready handshake.
- Branch/jump redirects from execute flush the queue and discard in-flight responses.

---
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, in-order imem fetch with credit flow and decode queue; `FETCH_PERF_COUNTERS_EN adds perfFetched/perfFlushed
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 2,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  output logic imemReqValid,
  input logic imemReqReady,
  output logic [ADDR_WIDTH-1:0] imemReqAddr,
  input logic imemRespValid,
  input logic [31:0] imemRespData,
  output logic instValid,
  input logic instReady,
  output logic [31:0] instruction,
  output logic [ADDR_WIDTH-1:0] instPc,
  input logic redirectValid,
  input logic [ADDR_WIDTH-1:0] redirectPc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perfFetched,
  output logic [31:0] perfFlushed
`endif
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] pc, nextPc;
  logic [PW:0] qCount, outstanding, dropCount, inFlight, nextDrop, nextCount;
  logic [PW-1:0] qHead, qTail, fHead, fTail;
  logic [31:0] qInst [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] qPc [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] fPc [QUEUE_DEPTH];
  logic reqFire, respIn, respDrop, push, pop;
  always_comb begin
    imemReqValid = !reset && !redirectValid && (qCount + outstanding) < DEPTH;
    imemReqAddr = pc;
    reqFire = imemReqValid && imemReqReady;
    respIn = !reset && imemRespValid && outstanding != '0;
    respDrop = respIn && (redirectValid || state == DRAIN);
    push = respIn && !respDrop;
    instValid = qCount != '0;
    pop = instValid && instReady && !redirectValid;
    instruction = instValid ? qInst[qHead] : NOP;
    instPc = instValid ? qPc[qHead] : '0;
    inFlight = outstanding - (PW+1)'(respIn);
    nextDrop = redirectValid ? inFlight : dropCount - (PW+1)'(respDrop);
    nextCount = redirectValid ? '0 : qCount + (PW+1)'(push) - (PW+1)'(pop);
    nextPc = redirectValid ? (redirectPc & ~ADDR_WIDTH'(3)) : reqFire ? pc + ADDR_WIDTH'(4) : pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RST_PC;
      qCount <= '0;
      outstanding <= '0;
      dropCount <= '0;
      qHead <= '0;
      qTail <= '0;
      fHead <= '0;
      fTail <= '0;
      state <= RUN;
    end else begin
      pc <= nextPc;
      qCount <= nextCount;
      outstanding <= inFlight + (PW+1)'(reqFire);
      dropCount <= nextDrop;
      state <= nextDrop != '0 ? DRAIN : RUN;
      qHead <= redirectValid ? '0 : qHead + PW'(pop);
      qTail <= redirectValid ? '0 : qTail + PW'(push);
      fHead <= redirectValid ? '0 : fHead + PW'(push);
      fTail <= redirectValid ? '0 : fTail + PW'(reqFire);
    end
  end
  always_ff @(posedge clk) begin
    if (reqFire) fPc[fTail] <= pc;
    if (push) begin
      qInst[qTail] <= imemRespData;
      qPc[qTail] <= fPc[fHead];
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perfFetched <= '0;
      perfFlushed <= '0;
    end else begin
      perfFetched <= perfFetched + 32'(push);
      perfFlushed <= perfFlushed + 32'(respDrop) + (redirectValid ? 32'(qCount) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench with queue-level reference model and directed literal pins
module tb_instruction_fetch;
  localparam int DEPTH = 2;
  logic clk, reset, imemReqValid, imemReqReady, imemRespValid, instValid, instReady, redirectValid;
  logic [31:0] imemReqAddr, imemRespData, instruction, instPc, redirectPc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perfFetched, perfFlushed;
`endif
  instruction_fetch dut (
    .clk(clk),
    .reset(reset),
    .imemReqValid(imemReqValid),
    .imemReqReady(imemReqReady),
    .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid),
    .imemRespData(imemRespData),
    .instValid(instValid),
    .instReady(instReady),
    .instruction(instruction),
    .instPc(instPc),
    .redirectValid(redirectValid),
    .redirectPc(redirectPc)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perfFetched(perfFetched),
    .perfFlushed(perfFlushed)
`endif
  );
  typedef struct {logic [31:0] pc; bit stale;} fl_t;
  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  typedef struct {int due; logic [31:0] data;} rsp_t;
  fl_t fl[$];
  ent_t q[$];
  rsp_t memQ[$];
  int nCmp = 0, nErr = 0, cyc = 0, lastDue = 0;
  int pReady, pInst, pRedir, latMin, latMax;
  bit rstReq, forceRedir, seen;
  logic [31:0] forceTarget, mPc, mFetched, mFlushed;
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask
  task automatic doReset();
    rstReq = 1;
    step(2);
    rstReq = 0;
    step(1);
  endtask
  task automatic waitValid(input string n);
    int i = 0;
    while (!instValid && i < 30) begin
      step(1);
      i++;
    end
    chk(n, 32'(instValid), 32'd1);
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    fl_t e;
    bit respV, expReqV, preValid;
    int due;
    reset = 1;
    imemReqReady = 0;
    imemRespValid = 0;
    imemRespData = 0;
    instReady = 0;
    redirectValid = 0;
    redirectPc = 0;
    forever begin
      @(negedge clk);
      reset = rstReq;
      imemReqReady = $urandom_range(99) < pReady;
      instReady = $urandom_range(99) < pInst;
      redirectValid = !rstReq && (forceRedir || $urandom_range(999) < pRedir);
      redirectPc = forceRedir ? forceTarget : 32'($urandom_range(1023));
      respV = memQ.size() != 0 && memQ[0].due <= cyc;
      imemRespValid = respV;
      imemRespData = respV ? memQ[0].data : $urandom;
      #1;
      expReqV = !reset && !redirectValid && (q.size() + fl.size() < DEPTH);
      if (!reset && seen) begin
        chk("imemReqValid", 32'(imemReqValid), 32'(expReqV));
        chk("imemReqAddr", imemReqAddr, mPc);
        chk("instValid", 32'(instValid), 32'(q.size() != 0));
        chk("instruction", instruction, q.size() != 0 ? q[0].inst : 32'h13);
        chk("instPc", instPc, q.size() != 0 ? q[0].pc : 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("perfFetched", perfFetched, mFetched);
        chk("perfFlushed", perfFlushed, mFlushed);
`endif
      end
      if (reset) begin
        seen = 1;
        mPc = 32'h0;
        q.delete();
        fl.delete();
        memQ.delete();
        mFetched = 0;
        mFlushed = 0;
        lastDue = cyc;
      end else begin
        preValid = q.size() != 0;
        if (respV) begin
          void'(memQ.pop_front());
          e = fl.pop_front();
        end
        if (redirectValid) begin
          mFlushed += 32'(q.size()) + 32'(respV);
          q.delete();
          foreach (fl[i]) fl[i].stale = 1;
          mPc = redirectPc & ~32'h3;
        end else begin
          if (preValid && instReady) void'(q.pop_front());
          if (respV) begin
            if (e.stale) mFlushed++;
            else begin
              q.push_back('{imemRespData, e.pc});
              mFetched++;
            end
          end
          if (expReqV && imemReqReady) begin
            due = cyc + $urandom_range(latMax, latMin);
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back('{due, memWord(mPc)});
            fl.push_back('{mPc, 1'b0});
            mPc += 4;
          end
        end
      end
      cyc++;
    end
  end
  initial begin
    rstReq = 1;
    pReady = 100;
    pInst = 100;
    pRedir = 0;
    latMin = 1;
    latMax = 1;
    forceRedir = 0;
    forceTarget = 0;
    doReset();
    chk("k0_reqValid", 32'(imemReqValid), 32'd1);
    chk("k0_addr", imemReqAddr, 32'h0);
    chk("k0_instValid", 32'(instValid), 32'd0);
    chk("k0_nop", instruction, 32'h13);
    step(1);
    chk("k1_addr", imemReqAddr, 32'h4);
    step(1);
    chk("k2_instValid", 32'(instValid), 32'd1);
    chk("k2_instPc", instPc, 32'h0);
    chk("k2_inst", instruction, 32'hCAFE_0000);
    step(1);
    chk("k3_instPc", instPc, 32'h4);
    pInst = 0;
    step(10);
    chk("stall_instValid", 32'(instValid), 32'd1);
    chk("stall_reqValid", 32'(imemReqValid), 32'd0);
    chk("stall_headPc", instPc, 32'h8);
    pInst = 100;
    doReset();
    step(2);
    pReady = 0;
    step(3);
    chk("memstall_addr", imemReqAddr, 32'h8);
    chk("memstall_reqValid", 32'(imemReqValid), 32'd1);
    pReady = 100;
    latMin = 3;
    latMax = 3;
    doReset();
    step(1);
    forceRedir = 1;
    forceTarget = 32'h100;
    step(1);
    forceRedir = 0;
    chk("redir_blocks_req", 32'(imemReqValid), 32'd0);
    waitValid("redir_wait0");
    chk("redir_pc0", instPc, 32'h100);
    chk("redir_inst0", instruction, 32'hCAFE_0100);
    step(1);
    waitValid("redir_wait1");
    chk("redir_pc1", instPc, 32'h104);
    latMin = 1;
    latMax = 1;
    doReset();
    step(1);
    forceRedir = 1;
    forceTarget = 32'h202;
    step(1);
    forceRedir = 0;
    chk("race_pre_valid", 32'(instValid), 32'd1);
    step(1);
    chk("race_empty", 32'(instValid), 32'd0);
    chk("race_addr_aligned", imemReqAddr, 32'h200);
    chk("race_reqValid", 32'(imemReqValid), 32'd1);
    latMin = 3;
    latMax = 3;
    pInst = 0;
    doReset();
    step(3);
    rstReq = 1;
    step(1);
    rstReq = 0;
    step(1);
    chk("rst_instValid", 32'(instValid), 32'd0);
    chk("rst_addr", imemReqAddr, 32'h0);
    chk("rst_reqValid", 32'(imemReqValid), 32'd1);
    step(2);
    chk("rst_late_ignored", 32'(instValid), 32'd0);
    pReady = 70;
    pInst = 60;
    pRedir = 40;
    latMin = 1;
    latMax = 4;
    for (int i = 0; i < 4000; i++) begin
      rstReq = $urandom_range(999) == 0;
      step(1);
    end
    rstReq = 0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
